// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson (twisted-ring) counter slice.
// Provides the direction encoding, the phase index width helper and
// the legal-pattern check used by both the decoder and the counter.
package johnson_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Widest counter this slice supports; the legality check is sized for it.
  localparam int MAX_STAGES = 16;

  // Width of the binary phase index for an n-stage counter (2n states).
  function automatic int phaseWidth(input int n);
    return $clog2(2 * n);
  endfunction

  // A legal Johnson pattern is a run of ones followed by a run of zeros
  // (in either order), so it has at most one transition between adjacent
  // bits. Counting transitions covers both the 0..01..1 and 1..10..0 families,
  // including all-zero and all-one. Bits at or above n are ignored.
  function automatic logic isLegal(input logic [MAX_STAGES-1:0] v, input int n);
    int transitions;
    transitions = 0;
    for (int i = 0; i < MAX_STAGES - 1; i++) begin
      if ((i < n - 1) && (v[i] != v[i+1])) begin
        transitions = transitions + 1;
      end
    end
    return (transitions <= 1);
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Purely combinational decoder for an N-stage Johnson counter state.
// Ports:
//   q     - current stage register value
//   phase - binary phase index (0 when q is illegal)
//   dec   - one-hot decode of phase (all-zero when q is illegal)
//   err   - high while q holds an illegal pattern
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              q,
  output logic [phaseWidth(N)-1:0]  phase,
  output logic [2*N-1:0]            dec,
  output logic                      err
);

  localparam int PW = phaseWidth(N);

  logic w_err;
  int   w_ones;

  // Population count of the stages; together with the MSB it fully
  // identifies a legal pattern's position in the sequence.
  always_comb begin
    w_ones = 0;
    for (int i = 0; i < N; i++) begin
      if (q[i]) begin
        w_ones = w_ones + 1;
      end
    end
  end

  // The first half of the sequence fills ones from the LSB (phase = ones);
  // the second half drains them, so with the MSB set the phase is 2N - ones.
  always_comb begin
    w_err = !isLegal(MAX_STAGES'(q), N);
    phase = '0;
    if (!w_err) begin
      if (q[N-1]) begin
        phase = PW'(2 * N - w_ones);
      end else begin
        phase = PW'(w_ones);
      end
    end
  end

  // One-hot decode; an illegal pattern suppresses every bit.
  always_comb begin
    dec = '0;
    for (int i = 0; i < 2 * N; i++) begin
      dec[i] = !w_err && (phase == PW'(i));
    end
  end

  assign err = w_err;

endmodule

// File: rtl/johnson_counter.sv
// N-stage Johnson (twisted-ring) counter with bidirectional stepping,
// parallel load, illegal-pattern self-correction and a registered wrap pulse.
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset
//   en      - step enable
//   dir     - step direction (DIR_UP / DIR_DOWN)
//   load    - parallel load strobe (wins over en)
//   ld_data - value loaded verbatim, may be illegal
//   q       - stage register
//   phase   - binary phase index of q
//   dec     - one-hot phase decode
//   wrap    - one-cycle pulse after a step across the phase 2N-1 / 0 boundary
//   err     - q holds an illegal pattern
module johnson_counter
  import johnson_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      dir,
  input  logic                      load,
  input  logic [N-1:0]              ld_data,
  output logic [N-1:0]              q,
  output logic [phaseWidth(N)-1:0]  phase,
  output logic [2*N-1:0]            dec,
  output logic                      wrap,
  output logic                      err
);

  localparam int PW = phaseWidth(N);

  logic [N-1:0]  r_q;
  logic          r_wrap;
  logic [N-1:0]  w_upNext;
  logic [N-1:0]  w_downNext;
  logic [PW-1:0] w_phase;
  logic          w_err;
  logic          w_upWrap;
  logic          w_downWrap;

  johnson_decode #(
    .N (N)
  ) u_decode (
    .q     (r_q),
    .phase (w_phase),
    .dec   (dec),
    .err   (w_err)
  );

  // Twisted-ring feedback: the entering stage takes the complement of the
  // stage leaving at the opposite end.
  assign w_upNext   = {r_q[N-2:0], ~r_q[N-1]};
  assign w_downNext = {~r_q[0], r_q[N-1:1]};

  // A step wraps when it leaves the last phase going up or phase 0 going down.
  assign w_upWrap   = !w_err && (w_phase == PW'(2 * N - 1));
  assign w_downWrap = !w_err && (w_phase == '0);

  // Next-state mux: reset, then load, then correction of an illegal
  // pattern (independent of en), then an enabled step, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_q    <= ld_data;
      r_wrap <= 1'b0;
    end else if (w_err) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else if (en) begin
      if (dir == DIR_UP) begin
        r_q    <= w_upNext;
        r_wrap <= w_upWrap;
      end else begin
        r_q    <= w_downNext;
        r_wrap <= w_downWrap;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign q     = r_q;
  assign wrap  = r_wrap;
  assign phase = w_phase;
  assign err   = w_err;

endmodule

// File: tb/tb_johnson_counter.sv
// Self-checking bench for johnson_counter with N=4: table-driven vectors
// fed through an expected-result queue, plus full-lap sequences in both
// directions.
module tb_johnson_counter;
  import johnson_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dir;
  logic       load;
  logic [3:0] ld_data;
  logic [3:0] q;
  logic [2:0] phase;
  logic [7:0] dec;
  logic       wrap;
  logic       err;

  int vectorsApplied = 0;
  int miscompares    = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] ldData;
    logic [3:0] expQ;
    logic       expWrap;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic       wrap;
    logic       err;
    logic [2:0] phase;
    logic [7:0] dec;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  logic [3:0] refSeq [8];

  johnson_counter #(
    .N (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .dir     (dir),
    .load    (load),
    .ld_data (ld_data),
    .q       (q),
    .phase   (phase),
    .dec     (dec),
    .wrap    (wrap),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Reference decode: position of q in the literal N=4 sequence table.
  function automatic exp_t refModel(input string name, input logic [3:0] expQ, input logic expWrap);
    exp_t e;
    e.name  = name;
    e.q     = expQ;
    e.wrap  = expWrap;
    e.err   = 1'b1;
    e.phase = 3'd0;
    e.dec   = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (refSeq[i] == expQ) begin
        e.err    = 1'b0;
        e.phase  = 3'(i);
        e.dec[i] = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic void addVec(input string name, input logic r, input logic e, input logic d,
                                 input logic l, input logic [3:0] ld, input logic [3:0] eq,
                                 input logic ew);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.dir = d; v.load = l;
    v.ldData = ld; v.expQ = eq; v.expWrap = ew;
    vecs.push_back(v);
  endfunction

  task automatic cmpField(input string name, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue its expected result.
  task automatic applyStimulus(input vec_t v);
    rst     = v.rst;
    en      = v.en;
    dir     = v.dir;
    load    = v.load;
    ld_data = v.ldData;
    sb.push_back(refModel(v.name, v.expQ, v.expWrap));
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expectation and compare it against the DUT outputs.
  task automatic checkOutput();
    exp_t e;
    vectorsApplied++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    cmpField({e.name, ".q"},     8'(q),     8'(e.q));
    cmpField({e.name, ".wrap"},  8'(wrap),  8'(e.wrap));
    cmpField({e.name, ".err"},   8'(err),   8'(e.err));
    cmpField({e.name, ".phase"}, 8'(phase), 8'(e.phase));
    cmpField({e.name, ".dec"},   dec,       e.dec);
  endtask

  // Hold en for 2N edges from startQ: expect the start value back and one wrap.
  task automatic runLap(input string name, input logic d, input logic [3:0] startQ);
    vec_t v;
    int   wrapCount;
    v.name = {name, "_load"}; v.rst = 1'b0; v.en = 1'b0; v.dir = d; v.load = 1'b1;
    v.ldData = startQ; v.expQ = startQ; v.expWrap = 1'b0;
    applyStimulus(v);
    checkOutput();
    load      = 1'b0;
    en        = 1'b1;
    dir       = d;
    wrapCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (wrap === 1'b1) wrapCount++;
    end
    en = 1'b0;
    vectorsApplied++;
    cmpField({name, ".wrapCount"}, 8'(wrapCount), 8'd1);
    cmpField({name, ".endQ"}, 8'(q), 8'(startQ));
  endtask

  initial begin
    refSeq = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    //      name        rst en dir ld  ldData   expQ     wrap
    addVec("reset0",    1, 1, 1, 0, 4'b0000, 4'b0000, 0);
    addVec("reset1",    1, 1, 1, 0, 4'b0000, 4'b0000, 0);
    addVec("up1",       0, 1, 1, 0, 4'b0000, 4'b0001, 0);
    addVec("up2",       0, 1, 1, 0, 4'b0000, 4'b0011, 0);
    addVec("up3",       0, 1, 1, 0, 4'b0000, 4'b0111, 0);
    addVec("up4",       0, 1, 1, 0, 4'b0000, 4'b1111, 0);
    addVec("up5",       0, 1, 1, 0, 4'b0000, 4'b1110, 0);
    addVec("up6",       0, 1, 1, 0, 4'b0000, 4'b1100, 0);
    addVec("up7",       0, 1, 1, 0, 4'b0000, 4'b1000, 0);
    addVec("upWrap",    0, 1, 1, 0, 4'b0000, 4'b0000, 1);
    addVec("upA",       0, 1, 1, 0, 4'b0000, 4'b0001, 0);
    addVec("upB",       0, 1, 1, 0, 4'b0000, 4'b0011, 0);
    addVec("upC",       0, 1, 1, 0, 4'b0000, 4'b0111, 0);
    addVec("dn1",       0, 1, 0, 0, 4'b0000, 4'b0011, 0);
    addVec("dn2",       0, 1, 0, 0, 4'b0000, 4'b0001, 0);
    addVec("dn3",       0, 1, 0, 0, 4'b0000, 4'b0000, 0);
    addVec("dnWrap",    0, 1, 0, 0, 4'b0000, 4'b1000, 1);
    addVec("revWrap",   0, 1, 1, 0, 4'b0000, 4'b0000, 1);
    addVec("ldIllegal", 0, 0, 1, 1, 4'b0101, 4'b0101, 0);
    addVec("fixIllegal",0, 0, 1, 0, 4'b0000, 4'b0000, 0);
    addVec("ldBeatsEn", 0, 1, 1, 1, 4'b1100, 4'b1100, 0);
    addVec("rstBeatsLd",1, 0, 1, 1, 4'b1100, 4'b0000, 0);
    addVec("ldHold",    0, 0, 1, 1, 4'b1110, 4'b1110, 0);
    for (int i = 0; i < 5; i++) begin
      addVec($sformatf("hold%0d", i), 0, 0, 1, 0, 4'b0000, 4'b1110, 0);
    end
    addVec("ld1000",    0, 0, 1, 1, 4'b1000, 4'b1000, 0);
    addVec("wrapAgain", 0, 1, 1, 0, 4'b0000, 4'b0000, 1);
    addVec("ldClrWrap", 0, 0, 1, 1, 4'b0011, 4'b0011, 0);
    addVec("ldIll2",    0, 0, 1, 1, 4'b1011, 4'b1011, 0);
    addVec("fixWithEn", 0, 1, 1, 0, 4'b0000, 4'b0000, 0);
    addVec("ld1000b",   0, 0, 1, 1, 4'b1000, 4'b1000, 0);
    addVec("rstNoWrap", 1, 1, 1, 0, 4'b0000, 4'b0000, 0);
    addVec("dnFromZero",0, 1, 0, 0, 4'b0000, 4'b1000, 1);
    addVec("wrapDrops", 0, 0, 0, 0, 4'b0000, 4'b1000, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    runLap("lapUp", DIR_UP, 4'b1100);
    runLap("lapDown", DIR_DOWN, 4'b0111);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
